// File: rtl/attn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : attn_pkg
// Description : Shared types and width helpers for the attention-score
//               scheduler (FSM state encoding, Q/K and score-matrix widths).
// Revision    : 1.0 - initial release
// ============================================================================
package attn_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } sched_state_t;

  // Packed width of one Q (or K) operand: L x N x E elements.
  function automatic int q_width(input int dw, input int l, input int n, input int e);
    return dw * l * n * e;
  endfunction

  // Packed width of one score matrix: L x N x L elements.
  function automatic int a_width(input int dw, input int l, input int n);
    return dw * l * n * l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first asserted
//               request at or after ptr, wrapping modulo NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] gnt
);

  logic           found;
  logic [IDW-1:0] idx;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/attn_score_sched.sv
`default_nettype none
// ============================================================================
// Module      : attn_score_sched
// Description : Round-robin scheduler sharing one attention_score engine among
//               NUM_REQ requesters. One job in flight; watchdog on engine time.
// Revision    : 1.0 - initial release
// ============================================================================
module attn_score_sched
  import attn_pkg::*;
#(
  parameter  int DATA_WIDTH  = 16,
  parameter  int L           = 8,
  parameter  int N           = 1,
  parameter  int E           = 8,
  parameter  int NUM_REQ     = 4,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int QW          = q_width(DATA_WIDTH, L, N, E),
  localparam int AW          = a_width(DATA_WIDTH, L, N),
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*QW-1:0] req_q,
  input  logic [NUM_REQ*QW-1:0] req_k,
  output logic                  eng_start,
  output logic [QW-1:0]         eng_q,
  output logic [QW-1:0]         eng_k,
  input  logic                  eng_done,
  input  logic [AW-1:0]         eng_a,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [AW-1:0]         resp_a,
  output logic                  resp_err,
  output logic                  busy
);

  // A disabled watchdog still needs a legal one-bit counter.
  localparam int WDW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WDW'(TIMEOUT_CYC - 1) : '0;

  sched_state_t     state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;
  logic [QW-1:0]    op_q_q, op_q_d, op_k_q, op_k_d;
  logic [AW-1:0]    a_q, a_d;
  logic             err_q, err_d;
  logic             rv_q, rv_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_idx;
  logic [QW-1:0]      q_sel, k_sel;
  logic               accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt)
  );

  // Grant only while idle and out of reset, so a held reset never shows a grant.
  assign req_ready  = (state_q == S_IDLE && rst_n) ? gnt : '0;
  assign accept     = |(req_valid & req_ready);
  assign eng_start  = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE);
  assign eng_q      = op_q_q;
  assign eng_k      = op_k_q;
  assign resp_valid = rv_q;
  assign resp_id    = id_q;
  assign resp_a     = a_q;
  assign resp_err   = err_q;

  // Encode the one-hot grant and pick the winning requester's operands.
  always_comb begin
    gnt_idx = '0;
    q_sel   = '0;
    k_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = IDW'(i);
        q_sel   = req_q[i*QW +: QW];
        k_sel   = req_k[i*QW +: QW];
      end
    end
  end

  // Next-state and datapath update for the IDLE/ISSUE/BUSY/RESP sequence.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    wd_cnt_d = wd_cnt_q;
    op_q_d   = op_q_q;
    op_k_d   = op_k_q;
    a_d      = a_q;
    err_d    = err_q;
    rv_d     = rv_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_q_d   = q_sel;
          op_k_d   = k_sel;
          id_d     = gnt_idx;
          rr_ptr_d = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_cnt_d = '0;
        state_d  = S_BUSY;
      end
      S_BUSY: begin
        // A completion in the same cycle as the timeout still counts as success.
        if (eng_done) begin
          a_d     = eng_a;
          err_d   = 1'b0;
          rv_d    = 1'b1;
          state_d = S_RESP;
        end else if (TIMEOUT_CYC != 0 && wd_cnt_q == WD_LAST) begin
          a_d     = '0;
          err_d   = 1'b1;
          rv_d    = 1'b1;
          state_d = S_RESP;
        end else if (wd_cnt_q != '1) begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          rv_d    = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      wd_cnt_q <= '0;
      op_q_q   <= '0;
      op_k_q   <= '0;
      a_q      <= '0;
      err_q    <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      wd_cnt_q <= wd_cnt_d;
      op_q_q   <= op_q_d;
      op_k_q   <= op_k_d;
      a_q      <= a_d;
      err_q    <= err_d;
      rv_q     <= rv_d;
    end
  end

endmodule
`default_nettype wire
